// File: rtl/prefetch_fetcher.sv
// rtl/prefetch_fetcher.sv - per-core instruction fetcher with associative line buffers
//
// Serves FETCH-stage PC requests from NUM_LINE_BUFS fully-associative line
// buffers. Each buffer holds LINE_WORDS instructions. A miss is filled by a
// single wide program-memory read into the least-recently-used buffer.
//
// Build option: PREFETCH_FETCHER_PREFETCH_EN enables next-sequential-line
// prefetch while the core is idle. When it is not defined, memory is read
// only on demand misses.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   req_valid/req_pc core request, held until req_ready
//   req_ready        one-cycle pulse, instruction valid in that cycle
//   instruction      registered fetched instruction
//   flush            invalidates every line buffer
//   mem_read_valid   program-memory read request
//   mem_read_address line-aligned word address of the read
//   mem_read_ready   memory returns mem_read_data this cycle
//   mem_read_data    whole line; word i at [i*DATA_BITS +: DATA_BITS]

module prefetch_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int LINE_WORDS            = 4,
  parameter int NUM_LINE_BUFS         = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          req_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]              req_pc,
  output logic                                          req_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0]              instruction,
  input  logic                                          flush,
  output logic                                          mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]              mem_read_address,
  input  logic                                          mem_read_ready,
  input  logic [LINE_WORDS*PROGRAM_MEM_DATA_BITS-1:0]   mem_read_data
);

  localparam int AW    = PROGRAM_MEM_ADDR_BITS;
  localparam int DW    = PROGRAM_MEM_DATA_BITS;
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int TAG_W = AW - OFF;
  localparam int IW    = $clog2(NUM_LINE_BUFS);

  localparam logic [IW-1:0] RANK_MRU = IW'(NUM_LINE_BUFS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RESPOND  = 2'd1;
  localparam logic [1:0] S_DEMAND   = 2'd2;
`ifdef PREFETCH_FETCHER_PREFETCH_EN
  localparam logic [1:0] S_PREFETCH = 2'd3;
`endif

  logic [1:0]               state, state_d;
  logic [NUM_LINE_BUFS-1:0] buf_valid;
  logic [TAG_W-1:0]         buf_tag  [NUM_LINE_BUFS];
  logic [DW-1:0]            buf_data [NUM_LINE_BUFS][LINE_WORDS];
  // Age rank per buffer: 0 = least recently used, NUM_LINE_BUFS-1 = most.
  logic [IW-1:0]            lru_rank [NUM_LINE_BUFS];

  // Line currently being read and the word the waiting request wants.
  // pend_store drops when a flush hits while the read is in flight.
  logic [TAG_W-1:0]         pend_tag, pend_tag_d;
  logic [OFF-1:0]           pend_word, pend_word_d;
  logic                     pend_store, pend_store_d;

  logic                     req_ready_d;
  logic [DW-1:0]            instr_d;
  logic                     mem_valid_d;
  logic [AW-1:0]            mem_addr_d;

  logic                     fill_en;
  logic                     touch_en;
  logic [IW-1:0]            touch_idx;

  logic [TAG_W-1:0]         req_tag;
  logic [OFF-1:0]           req_word;
  logic                     hit;
  logic [IW-1:0]            hit_idx;
  logic [IW-1:0]            victim_idx;
  logic [DW-1:0]            mem_words [LINE_WORDS];

  assign req_tag  = req_pc[AW-1:OFF];
  assign req_word = req_pc[OFF-1:0];

  always_comb begin
    for (int w = 0; w < LINE_WORDS; w++) begin
      mem_words[w] = mem_read_data[w*DW +: DW];
    end
  end

  // Fills never duplicate a resident tag, so at most one buffer matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINE_BUFS; i++) begin
      if (buf_valid[i] && (buf_tag[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < NUM_LINE_BUFS; i++) begin
      if (lru_rank[i] == '0) begin
        victim_idx = IW'(i);
      end
    end
  end

`ifdef PREFETCH_FETCHER_PREFETCH_EN
  // Prefetch bookkeeping: last served tag and whether its successor line
  // may still be prefetched (one prefetch per served tag).
  logic [TAG_W-1:0] last_tag, last_tag_d;
  logic             last_seen, last_seen_d;
  logic             pf_armed, pf_armed_d;
  logic [TAG_W-1:0] next_tag;
  logic             next_hit;
  logic             serve_en;
  logic [TAG_W-1:0] serve_tag;
  logic             serve_keep;
  logic             pf_issue;

  // Wraps naturally: the line after the last one is line 0.
  assign next_tag = last_tag + TAG_W'(1);

  always_comb begin
    next_hit = 1'b0;
    for (int i = 0; i < NUM_LINE_BUFS; i++) begin
      if (buf_valid[i] && (buf_tag[i] == next_tag)) begin
        next_hit = 1'b1;
      end
    end
  end

  always_comb begin
    last_tag_d  = last_tag;
    last_seen_d = last_seen;
    pf_armed_d  = pf_armed;
    if (serve_en) begin
      if (!serve_keep) begin
        // Served from data that was not kept: no prefetch follows it.
        last_seen_d = 1'b0;
        pf_armed_d  = 1'b0;
      end else if (!last_seen || (serve_tag != last_tag)) begin
        last_tag_d  = serve_tag;
        last_seen_d = 1'b1;
        pf_armed_d  = 1'b1;
      end
    end
    if (pf_issue || flush) begin
      pf_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_tag  <= '0;
      last_seen <= 1'b0;
      pf_armed  <= 1'b0;
    end else begin
      last_tag  <= last_tag_d;
      last_seen <= last_seen_d;
      pf_armed  <= pf_armed_d;
    end
  end
`endif

  always_comb begin
    state_d      = state;
    req_ready_d  = 1'b0;
    instr_d      = instruction;
    mem_valid_d  = mem_read_valid;
    mem_addr_d   = mem_read_address;
    pend_tag_d   = pend_tag;
    pend_word_d  = pend_word;
    pend_store_d = pend_store;
    fill_en      = 1'b0;
    touch_en     = 1'b0;
    touch_idx    = hit_idx;
`ifdef PREFETCH_FETCHER_PREFETCH_EN
    serve_en     = 1'b0;
    serve_tag    = req_tag;
    serve_keep   = 1'b0;
    pf_issue     = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (hit) begin
            instr_d     = buf_data[hit_idx][req_word];
            req_ready_d = 1'b1;
            touch_en    = 1'b1;
            touch_idx   = hit_idx;
            state_d     = S_RESPOND;
`ifdef PREFETCH_FETCHER_PREFETCH_EN
            serve_en    = 1'b1;
            serve_tag   = req_tag;
            serve_keep  = 1'b1;
`endif
          end else begin
            mem_valid_d  = 1'b1;
            mem_addr_d   = {req_tag, {OFF{1'b0}}};
            pend_tag_d   = req_tag;
            pend_word_d  = req_word;
            pend_store_d = 1'b1;
            state_d      = S_DEMAND;
          end
        end
`ifdef PREFETCH_FETCHER_PREFETCH_EN
        else if (pf_armed && !next_hit && !flush) begin
          mem_valid_d  = 1'b1;
          mem_addr_d   = {next_tag, {OFF{1'b0}}};
          pend_tag_d   = next_tag;
          pend_store_d = 1'b1;
          pf_issue     = 1'b1;
          state_d      = S_PREFETCH;
        end
`endif
      end

      S_RESPOND: begin
        state_d = S_IDLE;
      end

      S_DEMAND: begin
        if (mem_read_ready) begin
          mem_valid_d = 1'b0;
          instr_d     = mem_words[pend_word];
          req_ready_d = 1'b1;
          state_d     = S_RESPOND;
          // A flush before or during this edge means respond but do not keep.
          fill_en     = pend_store && !flush;
          touch_en    = pend_store && !flush;
          touch_idx   = victim_idx;
`ifdef PREFETCH_FETCHER_PREFETCH_EN
          serve_en    = 1'b1;
          serve_tag   = pend_tag;
          serve_keep  = pend_store && !flush;
`endif
        end else if (flush) begin
          pend_store_d = 1'b0;
        end
      end

`ifdef PREFETCH_FETCHER_PREFETCH_EN
      S_PREFETCH: begin
        if (mem_read_ready) begin
          mem_valid_d = 1'b0;
          fill_en     = pend_store && !flush;
          touch_en    = pend_store && !flush;
          touch_idx   = victim_idx;
          // A request for the line being returned is served from the bus
          // data; anything else goes back through IDLE for a fresh lookup.
          if (req_valid && (req_tag == pend_tag)) begin
            instr_d     = mem_words[req_word];
            req_ready_d = 1'b1;
            state_d     = S_RESPOND;
            serve_en    = 1'b1;
            serve_tag   = req_tag;
            serve_keep  = pend_store && !flush;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush) begin
          pend_store_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      req_ready        <= 1'b0;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      pend_tag         <= '0;
      pend_word        <= '0;
      pend_store       <= 1'b0;
      buf_valid        <= '0;
      for (int i = 0; i < NUM_LINE_BUFS; i++) begin
        buf_tag[i]  <= '0;
        lru_rank[i] <= IW'(i);
        for (int w = 0; w < LINE_WORDS; w++) begin
          buf_data[i][w] <= '0;
        end
      end
    end else begin
      state            <= state_d;
      req_ready        <= req_ready_d;
      instruction      <= instr_d;
      mem_read_valid   <= mem_valid_d;
      mem_read_address <= mem_addr_d;
      pend_tag         <= pend_tag_d;
      pend_word        <= pend_word_d;
      pend_store       <= pend_store_d;

      if (fill_en) begin
        buf_tag[victim_idx]   <= pend_tag;
        buf_valid[victim_idx] <= 1'b1;
        for (int w = 0; w < LINE_WORDS; w++) begin
          buf_data[victim_idx][w] <= mem_words[w];
        end
      end

      // Touched buffer becomes MRU; everything younger than it ages by one.
      if (touch_en) begin
        for (int i = 0; i < NUM_LINE_BUFS; i++) begin
          if (IW'(i) == touch_idx) begin
            lru_rank[i] <= RANK_MRU;
          end else if (lru_rank[i] > lru_rank[touch_idx]) begin
            lru_rank[i] <= lru_rank[i] - IW'(1);
          end
        end
      end

      // Flush overrides a same-cycle fill.
      if (flush) begin
        buf_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fetcher.sv
// tb/tb_prefetch_fetcher.sv - directed self-checking bench for prefetch_fetcher

module tb_prefetch_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [7:0]  req_pc;
  logic        req_ready;
  logic [15:0] instruction;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [63:0] mem_read_data;

  int errors = 0;
  int checks = 0;

  int         mem_wait = 2;
  int         rd_count = 0;
  logic [7:0] rd_last_addr = 8'h00;
  int         addr_changes = 0;
  logic [7:0] prev_addr = 8'h00;
  int         vcnt = 0;

  int          lat;
  logic [15:0] ins;

  prefetch_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .LINE_WORDS(4),
    .NUM_LINE_BUFS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_pc(req_pc),
    .req_ready(req_ready),
    .instruction(instruction),
    .flush(flush),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction stored at word address a is {8'hC3, a}.
  function automatic logic [63:0] line_of(input logic [7:0] a);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) begin
      l[i*16 +: 16] = {8'hC3, a + 8'(i)};
    end
    return l;
  endfunction

  // Memory model: after mem_read_valid has been high for mem_wait cycles,
  // mem_read_ready is raised for one cycle with the line data.
  initial begin
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_read_valid) begin
        mem_read_ready = 1'b0;
        vcnt = 0;
      end else if (!mem_read_ready) begin
        if (vcnt > 0 && mem_read_address !== prev_addr) addr_changes++;
        prev_addr = mem_read_address;
        if (vcnt == mem_wait) begin
          mem_read_ready = 1'b1;
          mem_read_data  = line_of(mem_read_address);
          rd_count++;
          rd_last_addr = mem_read_address;
        end else begin
          vcnt++;
        end
      end
    end
  end

  task automatic do_req(input logic [7:0] pc, output int l, output logic [15:0] data);
    l = 0;
    data = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (req_ready) begin
        l = c;
        data = instruction;
        break;
      end
    end
    req_valid = 1'b0;
    if (l != 0) begin
      @(posedge clk);
      #1;
      chk("ready_pulse", {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_pc    = 8'h00;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_instruction", {16'd0, instruction}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_read_address}, 32'd0);
    chk("rst_buf_valid", {30'd0, dut.buf_valid}, 32'd0);
    chk("rst_lru0_oldest", {31'd0, dut.lru_rank[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifndef PREFETCH_FETCHER_PREFETCH_EN
    // Demand miss on 0x05, memory ready after 2 wait cycles.
    mem_wait = 2;
    do_req(8'h05, lat, ins);
    chk("miss05_lat", lat, 32'd4);
    chk("miss05_ins", {16'd0, ins}, 32'hC305);
    chk("miss05_rdcnt", rd_count, 32'd1);
    chk("miss05_addr", {24'd0, rd_last_addr}, 32'h04);
    chk("miss05_buf0_valid", {31'd0, dut.buf_valid[0]}, 32'd1);
    chk("miss05_buf0_tag", {26'd0, dut.buf_tag[0]}, 32'd1);

    // Hit in the same line.
    do_req(8'h06, lat, ins);
    chk("hit06_lat", lat, 32'd1);
    chk("hit06_ins", {16'd0, ins}, 32'hC306);
    chk("hit06_rdcnt", rd_count, 32'd1);

    // LRU: fill 0x00, 0x04, 0x08 after a flush; 0x00 is evicted.
    pulse_flush();
    chk("flush_buf_valid", {30'd0, dut.buf_valid}, 32'd0);
    do_req(8'h00, lat, ins);
    chk("fill00_lat", lat, 32'd4);
    do_req(8'h04, lat, ins);
    chk("fill04_ins", {16'd0, ins}, 32'hC304);
    do_req(8'h08, lat, ins);
    chk("fill08_ins", {16'd0, ins}, 32'hC308);
    do_req(8'h05, lat, ins);
    chk("lru_hit05_lat", lat, 32'd1);
    do_req(8'h02, lat, ins);
    chk("lru_miss02_lat", lat, 32'd4);
    chk("lru_miss02_ins", {16'd0, ins}, 32'hC302);
    chk("lru_rdcnt", rd_count, 32'd5);

    // Flush during a demand read: still responds, line not kept.
    mem_wait = 3;
    fork
      do_req(8'h10, lat, ins);
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    chk("flushd_lat", lat, 32'd5);
    chk("flushd_ins", {16'd0, ins}, 32'hC310);
    chk("flushd_addr", {24'd0, rd_last_addr}, 32'h10);
    chk("flushd_buf_valid", {30'd0, dut.buf_valid}, 32'd0);
    do_req(8'h10, lat, ins);
    chk("rereq10_lat", lat, 32'd5);
    chk("rereq10_rdcnt", rd_count, 32'd7);
    chk("rereq10_buf_valid", {30'd0, dut.buf_valid}, 32'd1);

    // Flush on the same edge as the fill: buffer stays invalid.
    pulse_flush();
    mem_wait = 1;
    fork
      do_req(8'h31, lat, ins);
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    chk("flushf_lat", lat, 32'd3);
    chk("flushf_ins", {16'd0, ins}, 32'hC331);
    chk("flushf_buf_valid", {30'd0, dut.buf_valid}, 32'd0);
    do_req(8'h32, lat, ins);
    chk("flushf_remiss_lat", lat, 32'd3);
    chk("flushf_remiss_ins", {16'd0, ins}, 32'hC332);

    // Reset in the middle of a demand read.
    mem_wait = 10;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    chk("middemand_valid", {31'd0, mem_read_valid}, 32'd1);
    chk("middemand_addr", {24'd0, mem_read_address}, 32'h20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_mem_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rstmid_state", {30'd0, dut.state}, 32'd0);
    chk("rstmid_buf_valid", {30'd0, dut.buf_valid}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`else
    // Serve 0x04, idle: prefetch of line 0x08, then 0x09 hits.
    mem_wait = 1;
    do_req(8'h04, lat, ins);
    chk("pf_miss04_lat", lat, 32'd3);
    chk("pf_miss04_ins", {16'd0, ins}, 32'hC304);
    repeat (6) @(posedge clk);
    chk("pf_08_rdcnt", rd_count, 32'd2);
    chk("pf_08_addr", {24'd0, rd_last_addr}, 32'h08);
    do_req(8'h09, lat, ins);
    chk("pf_hit09_lat", lat, 32'd1);
    chk("pf_hit09_ins", {16'd0, ins}, 32'hC309);
    repeat (6) @(posedge clk);
    chk("pf_0c_addr", {24'd0, rd_last_addr}, 32'h0C);

    // Last line wraps to line 0.
    do_req(8'hFC, lat, ins);
    chk("pf_fc_ins", {16'd0, ins}, 32'hC3FC);
    repeat (6) @(posedge clk);
    chk("pf_wrap_addr", {24'd0, rd_last_addr}, 32'h00);
    chk("pf_wrap_rdcnt", rd_count, 32'd5);
    do_req(8'h00, lat, ins);
    chk("pf_hit00_lat", lat, 32'd1);
    chk("pf_hit00_ins", {16'd0, ins}, 32'hC300);
    repeat (6) @(posedge clk);
    chk("pf_04_rdcnt", rd_count, 32'd6);
    chk("pf_04_addr", {24'd0, rd_last_addr}, 32'h04);

    // Request arriving during a prefetch of its own line is served from the bus.
    mem_wait = 4;
    do_req(8'h40, lat, ins);
    chk("pf_miss40_lat", lat, 32'd6);
    @(posedge clk);
    do_req(8'h45, lat, ins);
    chk("pf_during_lat", lat, 32'd5);
    chk("pf_during_ins", {16'd0, ins}, 32'hC345);
    chk("pf_during_rdcnt", rd_count, 32'd8);
`endif

    chk("addr_stable", addr_changes, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
